// File: rtl/alarm_clock_pkg.sv
// ============================================================================
// Module  : alarm_clock_pkg
// Purpose : Shared BCD digit/time types and 24-hour limits for the alarm clock.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package alarm_clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t ms_hr;
    bcd_digit_t ls_hr;
    bcd_digit_t ms_min;
    bcd_digit_t ls_min;
  } alarm_time_t;

  localparam bcd_digit_t  MAX_MS_HR        = 4'd2;
  localparam bcd_digit_t  MAX_LS_HR        = 4'd9;
  localparam bcd_digit_t  MAX_LS_HR_20     = 4'd3;
  localparam bcd_digit_t  MAX_MS_MIN       = 4'd5;
  localparam bcd_digit_t  MAX_LS_MIN       = 4'd9;
  localparam logic [15:0] ALARM_RESET_TIME = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/alarm_reg_if.sv
// ============================================================================
// Module  : alarm_reg_if
// Purpose : Load strobe, new-time digits and stored alarm time bundle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alarm_reg_if;
  import alarm_clock_pkg::*;

  logic        load_new_a;
  alarm_time_t new_time;
  alarm_time_t alarm_time;

  modport master (output load_new_a, output new_time, input  alarm_time);
  modport slave  (input  load_new_a, input  new_time, output alarm_time);
endinterface

`default_nettype wire

// File: rtl/alarm_reg_bcd_time_check.sv
// ============================================================================
// Module  : bcd_time_check
// Purpose : Combinational legality check of a BCD HH:MM time (24-hour).
//           Only built when ALARM_REG_VALIDATE_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef ALARM_REG_VALIDATE_EN
module bcd_time_check
  import alarm_clock_pkg::*;
(
  input  wire bcd_digit_t ms_hr_i,
  input  wire bcd_digit_t ls_hr_i,
  input  wire bcd_digit_t ms_min_i,
  input  wire bcd_digit_t ls_min_i,
  output logic            valid_o
);

  logic w_hr_ok;
  logic w_min_ok;

  // Hours 20..23 need the tighter units limit.
  assign w_hr_ok  = (ms_hr_i <= MAX_MS_HR) &&
                    ((ms_hr_i == MAX_MS_HR) ? (ls_hr_i <= MAX_LS_HR_20)
                                            : (ls_hr_i <= MAX_LS_HR));
  assign w_min_ok = (ms_min_i <= MAX_MS_MIN) && (ls_min_i <= MAX_LS_MIN);
  assign valid_o  = w_hr_ok && w_min_ok;

endmodule
`endif

`default_nettype wire

// File: rtl/alarm_reg_core.sv
// ============================================================================
// Module  : alarm_reg_core
// Purpose : 16-bit alarm-time register with load strobe; optional legality
//           filter enabled by ALARM_REG_VALIDATE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_reg_core
  import alarm_clock_pkg::*;
(
  input  wire           clk_i,
  input  wire           rst_ni,
  alarm_reg_if.slave    bus_if
);

  alarm_time_t time_q;
  alarm_time_t time_d;
  logic        w_load_ok;

`ifdef ALARM_REG_VALIDATE_EN
  bcd_time_check u_check (
    .ms_hr_i  (bus_if.new_time.ms_hr),
    .ls_hr_i  (bus_if.new_time.ls_hr),
    .ms_min_i (bus_if.new_time.ms_min),
    .ls_min_i (bus_if.new_time.ls_min),
    .valid_o  (w_load_ok)
  );
`else
  assign w_load_ok = 1'b1;
`endif

  // All four digits move together; a rejected load leaves the whole word alone.
  always_comb begin
    time_d = time_q;
    if (bus_if.load_new_a && w_load_ok) begin
      time_d = bus_if.new_time;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      time_q <= alarm_time_t'(ALARM_RESET_TIME);
    end else begin
      time_q <= time_d;
    end
  end

  assign bus_if.alarm_time = time_q;

endmodule

`default_nettype wire

// File: rtl/alarm_reg.sv
// ============================================================================
// Module  : alarm_reg
// Purpose : Alarm-time storage register (HH:MM, BCD) with flat digit ports.
//           Optional load validation via ALARM_REG_VALIDATE_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alarm_reg
  import alarm_clock_pkg::*;
(
  input  wire        clk,
  input  wire        reset,
  input  wire        load_new_a,
  input  wire  [3:0] new_alarm_ms_hr,
  input  wire  [3:0] new_alarm_ls_hr,
  input  wire  [3:0] new_alarm_ms_min,
  input  wire  [3:0] new_alarm_ls_min,
  output logic [3:0] alarm_time_ms_hr,
  output logic [3:0] alarm_time_ls_hr,
  output logic [3:0] alarm_time_ms_min,
  output logic [3:0] alarm_time_ls_min
);

  alarm_reg_if u_bus ();

  assign u_bus.load_new_a = load_new_a;
  assign u_bus.new_time   = {new_alarm_ms_hr, new_alarm_ls_hr,
                             new_alarm_ms_min, new_alarm_ls_min};

  alarm_reg_core u_core (
    .clk_i  (clk),
    .rst_ni (reset),
    .bus_if (u_bus)
  );

  assign alarm_time_ms_hr  = u_bus.alarm_time.ms_hr;
  assign alarm_time_ls_hr  = u_bus.alarm_time.ls_hr;
  assign alarm_time_ms_min = u_bus.alarm_time.ms_min;
  assign alarm_time_ls_min = u_bus.alarm_time.ls_min;

endmodule

`default_nettype wire

// File: tb/tb_alarm_reg.sv
// ============================================================================
// Module  : tb_alarm_reg
// Purpose : Self-checking bench for alarm_reg (directed + random with model).
//           Honours ALARM_REG_VALIDATE_EN for the expected load filter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alarm_reg;
  import alarm_clock_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  o_ms_hr, o_ls_hr, o_ms_min, o_ls_min;
  logic [15:0] dut_time;
  logic [15:0] exp_time;
  bit          checking = 1'b0;
  int          total = 0;
  int          bad   = 0;

  alarm_reg_if tb_if ();

  always #5 clk = ~clk;

  alarm_reg dut (
    .clk               (clk),
    .reset             (reset),
    .load_new_a        (tb_if.load_new_a),
    .new_alarm_ms_hr   (tb_if.new_time.ms_hr),
    .new_alarm_ls_hr   (tb_if.new_time.ls_hr),
    .new_alarm_ms_min  (tb_if.new_time.ms_min),
    .new_alarm_ls_min  (tb_if.new_time.ls_min),
    .alarm_time_ms_hr  (o_ms_hr),
    .alarm_time_ls_hr  (o_ls_hr),
    .alarm_time_ms_min (o_ms_min),
    .alarm_time_ls_min (o_ls_min)
  );

  assign dut_time         = {o_ms_hr, o_ls_hr, o_ms_min, o_ls_min};
  assign tb_if.alarm_time = dut_time;

  // A legal time is hours 0..23 and minutes 0..59 built from decimal digits.
  function automatic bit legal(logic [15:0] v);
    int h, m;
    if (v[15:12] > 9 || v[11:8] > 9 || v[7:4] > 9 || v[3:0] > 9) return 1'b0;
    h = v[15:12] * 10 + v[11:8];
    m = v[7:4] * 10 + v[3:0];
    return (h < 24) && (m < 60);
  endfunction

  function automatic bit accept(logic [15:0] v);
`ifdef ALARM_REG_VALIDATE_EN
    return legal(v);
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus; the model absorbs the edge right after it.
  task automatic drive_cycle(input bit ld, input logic [15:0] v);
    tb_if.load_new_a = ld;
    tb_if.new_time   = v;
    @(posedge clk);
    if (reset === 1'b1 && ld && accept(v)) exp_time = v;
    #1;
  endtask

  task automatic assert_reset_midcycle();
    #2;
    reset    = 1'b0;
    exp_time = 16'h0000;
    #1;
    check("async_clear", dut_time, 16'h0000);
  endtask

  always @(negedge clk) begin
    if (checking) check("cycle", dut_time, exp_time);
  end

  function automatic logic [15:0] rand_time();
    logic [3:0] a, b, c, d;
    if ($urandom_range(0, 1) == 0) return 16'($urandom);
    a = 4'($urandom_range(0, 2));
    b = 4'((a == 4'd2) ? $urandom_range(0, 3) : $urandom_range(0, 9));
    c = 4'($urandom_range(0, 5));
    d = 4'($urandom_range(0, 9));
    return {a, b, c, d};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset            = 1'b1;
    tb_if.load_new_a = 1'b0;
    tb_if.new_time   = 16'h0000;
    exp_time         = 16'h0000;
    #1 reset = 1'b0;
    #1 check("reset_state", dut_time, 16'h0000);
    checking = 1'b1;

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 16'h1234);
      check("load_in_reset", dut_time, 16'h0000);
    end
    reset = 1'b1;

    drive_cycle(1'b1, 16'h1234);
    check("basic_1234", dut_time, 16'h1234);
    drive_cycle(1'b1, 16'h0959);
    check("basic_0959", dut_time, 16'h0959);

    drive_cycle(1'b1, 16'h2359);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 16'h1111);
      check("hold_2359", dut_time, 16'h2359);
    end

    assert_reset_midcycle();
    @(posedge clk); #1;
    reset = 1'b1;

    drive_cycle(1'b1, 16'h0123);
    drive_cycle(1'b1, 16'h0456);
    check("multi_load", dut_time, 16'h0456);
    tb_if.new_time = 16'h1742;
    assert_reset_midcycle();
    @(posedge clk); #1;
    check("load_lost", dut_time, 16'h0000);
    reset = 1'b1;
    drive_cycle(1'b1, 16'h1742);
    check("first_after_reset", dut_time, 16'h1742);

`ifdef ALARM_REG_VALIDATE_EN
    drive_cycle(1'b1, 16'h1200);
    drive_cycle(1'b1, 16'h5678);
    check("reject_5678", dut_time, 16'h1200);
    drive_cycle(1'b1, 16'h9abc);
    check("reject_9abc", dut_time, 16'h1200);
    drive_cycle(1'b1, 16'h2400);
    check("reject_2400", dut_time, 16'h1200);
    drive_cycle(1'b1, 16'h2359);
    check("accept_2359", dut_time, 16'h2359);
`else
    drive_cycle(1'b1, 16'hdef0);
    check("verbatim_def0", dut_time, 16'hdef0);
`endif

    for (int i = 0; i < 400; i++) begin
      if (reset == 1'b0) reset = 1'b1;
      if ($urandom_range(0, 39) == 0) begin
        tb_if.load_new_a = 1'($urandom);
        tb_if.new_time   = rand_time();
        assert_reset_midcycle();
        @(posedge clk); #1;
      end else begin
        drive_cycle(($urandom_range(0, 1) == 1), rand_time());
      end
    end
    reset = 1'b1;
    drive_cycle(1'b0, 16'h0000);

    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alarm_reg.md
# alarm_reg

Alarm-time storage register for the digital alarm clock. Holds the programmed alarm time as four BCD digits (HH:MM) and loads a new time from the key/setting path when `load_new_a` is asserted. Its outputs feed the alarm comparator and the display mux continuously.

## Interface
Parameters:
- None. Digit width is fixed at 4 bits (BCD).

Ports (order is fixed; positional instantiation is used):
- `clk`  input  1  system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `load_new_a`  input  1  load strobe; when high, the new alarm time is captured at the next rising edge.
- `new_alarm_ms_hr`  input  4  new alarm hours tens digit (BCD).
- `new_alarm_ls_hr`  input  4  new alarm hours units digit (BCD).
- `new_alarm_ms_min`  input  4  new alarm minutes tens digit (BCD).
- `new_alarm_ls_min`  input  4  new alarm minutes units digit (BCD).
- `alarm_time_ms_hr`  output  4  stored alarm hours tens digit.
- `alarm_time_ls_hr`  output  4  stored alarm hours units digit.
- `alarm_time_ms_min`  output  4  stored alarm minutes tens digit.
- `alarm_time_ls_min`  output  4  stored alarm minutes units digit.

## Operation
- State: one 16-bit register, `{ms_hr, ls_hr, ms_min, ls_min}`. All outputs are driven directly from this register, with no combinational path from the inputs.
- `reset` low: all four digits are forced to 0 immediately (00:00), independent of `clk`.
- `reset` high, `load_new_a` high: the four input digits are captured at the rising edge. All four digits update atomically.
- `reset` high, `load_new_a` low: the register holds its value, regardless of activity on the input digits.
- Reset dominates load. If `reset` is low, `load_new_a` is ignored.
- No arithmetic and no wrap-around. The value is stored verbatim, except where the validation filter applies (see Configuration).

## Timing
- Load latency: 1 cycle. The outputs show the new value after the rising edge at which `load_new_a` was sampled high.
- When `load_new_a` is held high for several cycles, the register tracks the inputs every cycle. The last sampled value is retained after `load_new_a` falls.
- Reset assertion is asynchronous, and the outputs go to 0 without waiting for a clock edge.
- Reset deassertion is synchronised externally. The first load is possible at the first rising edge after `reset` goes high.
- If `reset` is asserted in the middle of a multi-cycle load, the register clears immediately and the load is lost.
- No handshake exists and no busy state: a load is accepted on every cycle.

## Configuration
- Macro: `ALARM_REG_VALIDATE_EN`.
- Defined:
  - A load is accepted only if the input forms a legal 24-hour BCD time: `ms_hr` ≤ 2; `ls_hr` ≤ 9, or ≤ 3 when `ms_hr` = 2; `ms_min` ≤ 5; `ls_min` ≤ 9.
  - An illegal load is silently dropped and the register holds its previous value. No partial update occurs.
- Not defined: any 16-bit value is loaded verbatim, including non-BCD nibbles such as A–F.

## Structure
- Shared package `alarm_clock_pkg` holds:
  - the BCD digit type (4-bit);
  - limit constants `MAX_MS_HR=2`, `MAX_LS_HR=9`, `MAX_LS_HR_20=3`, `MAX_MS_MIN=5`, `MAX_LS_MIN=9`;
  - the reset time constant `ALARM_RESET_TIME=16'h0000`.
- One natural sub-module, `bcd_time_check`. It is purely combinational: four digits in, one `valid` bit out. It is instantiated only under `ALARM_REG_VALIDATE_EN`.

## Test plan
- Reset: hold `reset` low, then apply `load_new_a=1` with inputs `16'h1234` -> outputs stay `0000` throughout. Check that the outputs clear asynchronously mid-cycle from a nonzero value.
- Basic load: with `reset` high, `load_new_a=1` and inputs `16'h1234` -> outputs read `1,2,3,4` one edge later. Changing the inputs to `16'h0959` -> outputs read `0,9,5,9` on the next edge.
- Hold: load `16'h2359`, drop `load_new_a`, drive inputs `16'h1111` for 5 cycles -> outputs remain `2,3,5,9`.
- Reset mid-load: with `load_new_a` held high and inputs cycling, assert `reset` low -> outputs become `0000` immediately. Deassert `reset` -> the next edge loads the current inputs.
- Illegal value with the macro defined: load `16'h1200`, then present `16'h5678`, `16'h9abc` and `16'h2400` -> outputs stay `1200`. Then present `16'h2359` -> outputs become `2359`.
- Illegal value with the macro undefined: present `16'hdef0` with `load_new_a=1` -> outputs become `d,e,f,0`.
